data_memory_lsu: RTL and testbench

//  Byte-addressed data memory with an integrated load/store front end for the RISC-V datapath.

---
 rtl/dmem_pkg.sv | 26 ++
 rtl/dmem_byte_array.sv | 39 +++
 rtl/data_memory_lsu.sv | 133 +++++++++++++
 tb/tb_data_memory_lsu.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared encodings and lane-mask helper for the data memory LSU
package dmem_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_D = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } lsu_state_e;

    // Byte-lane enables for an access of 1<<size bytes starting at lane addr_lsbs.
    function automatic logic [7:0] byte_mask(input logic [1:0] size, input logic [2:0] addr_lsbs);
        logic [7:0] base;
        case (size)
            SZ_B:    base = 8'h01;
            SZ_H:    base = 8'h03;
            SZ_W:    base = 8'h0F;
            default: base = 8'hFF;
        endcase
        return base << addr_lsbs;
    endfunction

endpackage

// File: rtl/dmem_byte_array.sv
// rtl/dmem_byte_array.sv - DEPTH x 8 storage with byte-enable lanes and synchronous row read
module dmem_byte_array #(
    parameter int XLEN  = 64,
    parameter int DEPTH = 256,
    localparam int LANES = XLEN / 8,
    localparam int ROW_W = $clog2(DEPTH / LANES)
) (
    input  logic             clk,
    input  logic [ROW_W-1:0] row,
    input  logic [LANES-1:0] wr_be,
    input  logic [XLEN-1:0]  wr_data,
    input  logic             rd_en,
    output logic [XLEN-1:0]  rd_data
);

    logic [XLEN-1:0] mem [DEPTH / LANES];
    logic [XLEN-1:0] rd_data_q;
    logic [XLEN-1:0] rd_data_d;

    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = mem[row];
        end
    end

    // Storage is deliberately not reset; only the LSU control state is.
    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (wr_be[i]) begin
                mem[row][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
        rd_data_q <= rd_data_d;
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/data_memory_lsu.sv
// rtl/data_memory_lsu.sv - byte-addressed data memory with load/store front end
module data_memory_lsu
    import dmem_pkg::*;
#(
    parameter int XLEN   = 64,
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [XLEN-1:0]   resp_rdata,
    output logic              resp_err
);

    localparam int LANES  = XLEN / 8;
    localparam int LANE_W = $clog2(LANES);
    localparam int MEM_AW = $clog2(DEPTH);

    lsu_state_e        state_q, state_d;
    logic              err_q, err_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [LANE_W-1:0] off_q, off_d;

    logic              accept;
    logic [3:0]        n_bytes;
    logic [ADDR_W:0]   last_addr;
    logic              misaligned, out_of_range, illegal_size, req_err;
    logic [LANE_W-1:0] lane_off;
    logic [7:0]        mask8;
    logic [LANES-1:0]  wr_be;
    logic [XLEN-1:0]   wr_data;
    logic              rd_en;
    logic [XLEN-1:0]   rd_row;
    logic [XLEN-1:0]   shifted, keep, ext;
    logic              sign_bit;

    assign resp_valid = (state_q == ST_RESP);
    assign req_ready  = !resp_valid || resp_ready;
    assign accept     = req_valid && req_ready;

    // Extra carry bit on last_addr so accesses straddling the top of the address space still flag.
    assign n_bytes      = 4'd1 << req_size;
    assign last_addr    = {1'b0, req_addr} + (ADDR_W+1)'(n_bytes) - (ADDR_W+1)'(1);
    assign misaligned   = |(req_addr[2:0] & (n_bytes[2:0] - 3'd1));
    assign out_of_range = (last_addr >= (ADDR_W+1)'(DEPTH));
    assign illegal_size = (req_size == SZ_D) && (XLEN == 32);
    assign req_err      = misaligned || out_of_range || illegal_size;

    assign lane_off = req_addr[LANE_W-1:0];
    assign mask8    = byte_mask(req_size, 3'(lane_off));
    assign wr_be    = (accept && req_we && !req_err) ? mask8[LANES-1:0] : '0;
    assign wr_data  = req_wdata << {lane_off, 3'b000};
    assign rd_en    = accept && !req_we && !req_err;

    dmem_byte_array #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH)
    ) u_array (
        .clk     (clk),
        .row     (req_addr[MEM_AW-1:LANE_W]),
        .wr_be   (wr_be),
        .wr_data (wr_data),
        .rd_en   (rd_en),
        .rd_data (rd_row)
    );

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        we_d    = we_q;
        size_d  = size_q;
        uns_d   = uns_q;
        off_d   = off_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_RESP;
            ST_RESP: if (resp_ready && !accept) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (accept) begin
            err_d  = req_err;
            we_d   = req_we;
            size_d = req_size;
            uns_d  = req_unsigned;
            off_d  = lane_off;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            size_q  <= SZ_B;
            uns_q   <= 1'b0;
            off_q   <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            we_q    <= we_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            off_q   <= off_d;
        end
    end

    // Extension: keep the low 8N bits, fill the rest with the sign bit for signed loads.
    always_comb begin
        shifted = rd_row >> {off_q, 3'b000};
        keep    = '1;
        case (size_q)
            SZ_B:    begin keep = XLEN'(8'hFF);         sign_bit = shifted[7];  end
            SZ_H:    begin keep = XLEN'(16'hFFFF);      sign_bit = shifted[15]; end
            SZ_W:    begin keep = XLEN'(32'hFFFF_FFFF); sign_bit = shifted[31]; end
            default: begin keep = '1;                   sign_bit = 1'b0;        end
        endcase
        ext = (shifted & keep) | ((sign_bit && !uns_q) ? ~keep : '0);
    end

    assign resp_rdata = (resp_valid && !err_q && !we_q) ? ext : '0;
    assign resp_err   = resp_valid && err_q;

endmodule

// File: tb/tb_data_memory_lsu.sv
// tb/tb_data_memory_lsu.sv - self-checking bench for data_memory_lsu
module tb_data_memory_lsu;

    localparam int DEPTH_TB = 256;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [8:0]  req_addr;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_rdata;
    logic        resp_err;

    int n_cmp;
    int n_bad;
    logic [7:0] ref_mem [DEPTH_TB];

    typedef struct {
        logic        we;
        logic [1:0]  sz;
        logic        uns;
        logic [8:0]  addr;
        logic [63:0] wd;
        logic        err;
        logic [63:0] rd;
    } vec_t;

    vec_t tab[$];

    data_memory_lsu #(
        .XLEN   (64),
        .DEPTH  (256),
        .ADDR_W (9)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: byte array plus plain arithmetic for alignment, range and extension.
    task automatic model(input logic we, input logic [1:0] sz, input logic uns, input logic [8:0] addr,
                         input logic [63:0] wd, output logic e, output logic [63:0] rd);
        int n;
        int a;
        n  = 1 << sz;
        a  = int'(addr);
        e  = ((a % n) != 0) || (a + n > DEPTH_TB);
        rd = '0;
        if (!e) begin
            if (we) begin
                for (int i = 0; i < n; i++) ref_mem[a+i] = wd[8*i +: 8];
            end else begin
                for (int i = 0; i < n; i++) rd = rd | (64'(ref_mem[a+i]) << (8*i));
                if (!uns && n < 8 && rd[8*n-1]) rd = rd | ~((64'd1 << (8*n)) - 64'd1);
            end
        end
    endtask

    // Called #1 after a rising edge; returns #1 after the accepting edge with req_valid still high.
    task automatic issue(input logic we, input logic [1:0] sz, input logic uns, input logic [8:0] addr,
                         input logic [63:0] wd, input logic e_exp, input logic [63:0] rd_exp, input string tag);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wd;
        resp_ready   = 1'b1;
        #1;
        chk({tag, " req_ready"}, 64'(req_ready), 64'd1);
        @(posedge clk);
        #1;
        chk({tag, " resp_valid"}, 64'(resp_valid), 64'd1);
        chk({tag, " resp_err"}, 64'(resp_err), 64'(e_exp));
        chk({tag, " resp_rdata"}, resp_rdata, rd_exp);
    endtask

    task automatic issue_m(input logic we, input logic [1:0] sz, input logic uns, input logic [8:0] addr,
                           input logic [63:0] wd, input string tag);
        logic        e;
        logic [63:0] rd;
        model(we, sz, uns, addr, wd, e, rd);
        issue(we, sz, uns, addr, wd, e, rd, tag);
    endtask

    task automatic idle();
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [63:0] x;
        logic [63:0] ld_exp;
        logic        e;
        logic [1:0]  sz;
        logic [8:0]  a;
        int          n;

        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        req_valid = 1'b0;
        req_we = 1'b0;
        req_size = 2'd0;
        req_unsigned = 1'b0;
        req_addr = '0;
        req_wdata = '0;
        resp_ready = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("reset resp_valid", 64'(resp_valid), 64'd0);
        chk("reset resp_rdata", resp_rdata, 64'd0);
        chk("reset resp_err", 64'(resp_err), 64'd0);
        chk("reset req_ready", 64'(req_ready), 64'd1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < DEPTH_TB / 8; i++) issue_m(1'b1, 2'd3, 1'b0, 9'(i * 8), 64'd0, "init");

        tab.push_back('{1'b1, 2'd3, 1'b0, 9'h010, 64'h1122334455667788, 1'b0, 64'h0});
        tab.push_back('{1'b0, 2'd3, 1'b0, 9'h010, 64'h0, 1'b0, 64'h1122334455667788});
        tab.push_back('{1'b1, 2'd0, 1'b0, 9'h013, 64'h80, 1'b0, 64'h0});
        tab.push_back('{1'b0, 2'd0, 1'b0, 9'h013, 64'h0, 1'b0, 64'hFFFFFFFFFFFFFF80});
        tab.push_back('{1'b0, 2'd0, 1'b1, 9'h013, 64'h0, 1'b0, 64'h80});
        tab.push_back('{1'b0, 2'd2, 1'b0, 9'h010, 64'h0, 1'b0, 64'hFFFFFFFF80667788});
        tab.push_back('{1'b0, 2'd1, 1'b0, 9'h011, 64'h0, 1'b1, 64'h0});
        tab.push_back('{1'b1, 2'd3, 1'b0, 9'h0F8, 64'hAABBCCDDEEFF0011, 1'b0, 64'h0});
        tab.push_back('{1'b1, 2'd2, 1'b0, 9'h0FE, 64'h12345678, 1'b1, 64'h0});
        tab.push_back('{1'b0, 2'd3, 1'b0, 9'h0F8, 64'h0, 1'b0, 64'hAABBCCDDEEFF0011});
        tab.push_back('{1'b0, 2'd0, 1'b0, 9'h100, 64'h0, 1'b1, 64'h0});
        tab.push_back('{1'b0, 2'd1, 1'b1, 9'h0FE, 64'h0, 1'b0, 64'hAABB});
        tab.push_back('{1'b0, 2'd1, 1'b0, 9'h0FE, 64'h0, 1'b0, 64'hFFFFFFFFFFFFAABB});
        tab.push_back('{1'b0, 2'd2, 1'b1, 9'h0FC, 64'h0, 1'b0, 64'hAABBCCDD});
        tab.push_back('{1'b0, 2'd2, 1'b0, 9'h0FC, 64'h0, 1'b0, 64'hFFFFFFFFAABBCCDD});
        tab.push_back('{1'b1, 2'd1, 1'b0, 9'h1FE, 64'h5555, 1'b1, 64'h0});
        tab.push_back('{1'b0, 2'd3, 1'b0, 9'h1F8, 64'h0, 1'b1, 64'h0});
        tab.push_back('{1'b1, 2'd1, 1'b1, 9'h016, 64'hFFFFFFFFFFFFBEEF, 1'b0, 64'h0});
        tab.push_back('{1'b0, 2'd3, 1'b0, 9'h010, 64'h0, 1'b0, 64'hBEEF334480667788});

        foreach (tab[i]) begin
            model(tab[i].we, tab[i].sz, tab[i].uns, tab[i].addr, tab[i].wd, e, x);
            issue(tab[i].we, tab[i].sz, tab[i].uns, tab[i].addr, tab[i].wd, tab[i].err, tab[i].rd,
                  $sformatf("vec%0d", i));
        end

        // Stall: response must hold for 3 cycles while a new request waits.
        idle();
        model(1'b0, 2'd3, 1'b0, 9'h010, 64'h0, e, ld_exp);
        issue(1'b0, 2'd3, 1'b0, 9'h010, 64'h0, 1'b0, ld_exp, "stall_ld");
        resp_ready   = 1'b0;
        req_valid    = 1'b1;
        req_we       = 1'b0;
        req_size     = 2'd0;
        req_unsigned = 1'b1;
        req_addr     = 9'h010;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("stall%0d req_ready", k), 64'(req_ready), 64'd0);
            @(posedge clk);
            #1;
            chk($sformatf("stall%0d resp_valid", k), 64'(resp_valid), 64'd1);
            chk($sformatf("stall%0d resp_rdata", k), resp_rdata, ld_exp);
        end
        issue_m(1'b0, 2'd0, 1'b1, 9'h010, 64'h0, "stall_release");

        // Back-to-back store then load of the same address.
        x = {$urandom, $urandom};
        issue_m(1'b1, 2'd3, 1'b0, 9'h020, x, "b2b_sd");
        issue(1'b0, 2'd3, 1'b0, 9'h020, 64'h0, 1'b0, x, "b2b_ld");
        idle();
        chk("b2b drained resp_valid", 64'(resp_valid), 64'd0);

        // Asynchronous reset while a response is pending.
        issue_m(1'b0, 2'd3, 1'b0, 9'h020, 64'h0, "rst_pre");
        req_valid  = 1'b0;
        resp_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async rst resp_valid", 64'(resp_valid), 64'd0);
        chk("async rst resp_rdata", resp_rdata, 64'd0);
        chk("async rst resp_err", 64'(resp_err), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        issue(1'b0, 2'd3, 1'b0, 9'h020, 64'h0, 1'b0, x, "post_rst_ld");

        // Randomized traffic against the reference model.
        for (int it = 0; it < 400; it++) begin
            if ($urandom_range(0, 7) == 0) idle();
            sz = 2'($urandom_range(0, 3));
            n  = 1 << sz;
            if ($urandom_range(0, 5) == 0) a = 9'($urandom_range(0, 511));
            else a = 9'($urandom_range(0, 255) & ~(n - 1));
            issue_m(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, {$urandom, $urandom},
                    $sformatf("rnd%0d", it));
        end
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
